// File: rtl/id_stage.sv
// ID stage of a five-stage RV32I pipeline: decodes the IF/ID slot, detects
// load-use hazards against the instruction in EX, and holds the ID/EX register.
module id_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        id_ready,
  input  logic        ex_ready,
  input  logic        flush,
  output logic [4:0]  addr_rs1,
  output logic [4:0]  addr_rs2,
  input  logic [31:0] rs1_value_,
  input  logic [31:0] rs2_value_,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs1_value,
  output logic [31:0] ex_rs2_value,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [2:0]  ex_funct3,
  output logic [3:0]  ex_alu_op,
  output logic        ex_alu_src_imm,
  output logic        ex_pc_src,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_reg_write,
  output logic        ex_branch,
  output logic        ex_jump,
  output logic        ex_jalr,
  output logic        ex_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1Value;
    logic [31:0] rs2Value;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [3:0]  aluOp;
    logic        aluSrcImm;
    logic        pcSrc;
    logic        memRead;
    logic        memWrite;
    logic        regWrite;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic        illegal;
  } idEx_t;

  // ALU operation from the opcode/funct fields; shared by the live decode and the bubble
  function automatic logic [3:0] decodeAluOp(input logic [6:0] opcode,
                                             input logic [2:0] funct3,
                                             input logic       funct7b5);
    logic [3:0] op;
    op = ALU_ADD;
    case (opcode)
      OPC_LUI:    op = ALU_PASSB;
      OPC_BRANCH: op = ALU_SUB;
      OPC_OPIMM, OPC_OP: begin
        case (funct3)
          3'b000:  op = (opcode == OPC_OP && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  op = ALU_SLL;
          3'b010:  op = ALU_SLT;
          3'b011:  op = ALU_SLTU;
          3'b100:  op = ALU_XOR;
          3'b101:  op = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  op = ALU_OR;
          default: op = ALU_AND;
        endcase
      end
      default:    op = ALU_ADD;
    endcase
    return op;
  endfunction

  logic [6:0]  w_opcode;
  logic [31:0] w_immI, w_immS, w_immB, w_immU, w_immJ;
  logic        w_usesRs1, w_usesRs2, w_loadUse;
  idEx_t       w_dec, w_bubble, r_idEx;

  assign w_opcode = if_instr[6:0];
  assign addr_rs1 = if_instr[19:15];
  assign addr_rs2 = if_instr[24:20];

  assign w_immI = {{20{if_instr[31]}}, if_instr[31:20]};
  assign w_immS = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign w_immB = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
  assign w_immU = {if_instr[31:12], 12'h000};
  assign w_immJ = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};

  // Decode the current IF/ID slot into the form the ID/EX register stores
  always_comb begin
    w_dec          = '0;
    w_usesRs1      = 1'b1;
    w_usesRs2      = 1'b0;
    w_dec.valid    = if_valid;
    w_dec.pc       = if_pc;
    w_dec.rs1Value = rs1_value_;
    w_dec.rs2Value = rs2_value_;
    w_dec.rs1      = if_instr[19:15];
    w_dec.rs2      = if_instr[24:20];
    w_dec.rd       = if_instr[11:7];
    w_dec.funct3   = if_instr[14:12];
    w_dec.aluOp    = decodeAluOp(w_opcode, if_instr[14:12], if_instr[30]);
    case (w_opcode)
      OPC_LUI: begin
        w_usesRs1 = 1'b0; w_dec.imm = w_immU;
        w_dec.aluSrcImm = 1'b1; w_dec.regWrite = 1'b1;
      end
      OPC_AUIPC: begin
        w_usesRs1 = 1'b0; w_dec.imm = w_immU;
        w_dec.aluSrcImm = 1'b1; w_dec.pcSrc = 1'b1; w_dec.regWrite = 1'b1;
      end
      OPC_JAL: begin
        w_usesRs1 = 1'b0; w_dec.imm = w_immJ;
        w_dec.aluSrcImm = 1'b1; w_dec.pcSrc = 1'b1; w_dec.jump = 1'b1; w_dec.regWrite = 1'b1;
      end
      OPC_JALR: begin
        w_dec.imm = w_immI;
        w_dec.aluSrcImm = 1'b1; w_dec.jump = 1'b1; w_dec.jalr = 1'b1; w_dec.regWrite = 1'b1;
      end
      OPC_BRANCH: begin
        w_usesRs2 = 1'b1; w_dec.imm = w_immB; w_dec.branch = 1'b1;
      end
      OPC_LOAD: begin
        w_dec.imm = w_immI;
        w_dec.aluSrcImm = 1'b1; w_dec.memRead = 1'b1; w_dec.regWrite = 1'b1;
      end
      OPC_STORE: begin
        w_usesRs2 = 1'b1; w_dec.imm = w_immS;
        w_dec.aluSrcImm = 1'b1; w_dec.memWrite = 1'b1;
      end
      OPC_OPIMM: begin
        w_dec.imm = w_immI;
        w_dec.aluSrcImm = 1'b1; w_dec.regWrite = 1'b1;
      end
      OPC_OP: begin
        w_usesRs2 = 1'b1; w_dec.regWrite = 1'b1;
      end
      default: begin
        w_dec.illegal = 1'b1;
        w_dec.funct3  = 3'b000;
      end
    endcase
    if (w_dec.rd == 5'd0) w_dec.regWrite = 1'b0;
  end

  // Bubble contents: invalid, all flags clear, multi-bit controls taken from the NOP decode
  always_comb begin
    w_bubble        = '0;
    w_bubble.funct3 = NOP_INSTR[14:12];
    w_bubble.aluOp  = decodeAluOp(NOP_INSTR[6:0], NOP_INSTR[14:12], NOP_INSTR[30]);
  end

  assign w_loadUse = r_idEx.valid & r_idEx.memRead & (r_idEx.rd != 5'd0) & if_valid &
                     ((w_usesRs1 & (if_instr[19:15] == r_idEx.rd)) |
                      (w_usesRs2 & (if_instr[24:20] == r_idEx.rd)));
  assign id_ready  = ex_ready & ~w_loadUse;

  // ID/EX register: flush beats stall, stall beats load-use bubble, otherwise capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              r_idEx <= '0;
    else if (flush)        r_idEx <= w_bubble;
    else if (!ex_ready)    r_idEx <= r_idEx;
    else if (w_loadUse)    r_idEx <= w_bubble;
    else if (!if_valid)    r_idEx <= w_bubble;
    else                   r_idEx <= w_dec;
  end

  assign ex_valid       = r_idEx.valid;
  assign ex_pc          = r_idEx.pc;
  assign ex_rs1_value   = r_idEx.rs1Value;
  assign ex_rs2_value   = r_idEx.rs2Value;
  assign ex_imm         = r_idEx.imm;
  assign ex_rs1         = r_idEx.rs1;
  assign ex_rs2         = r_idEx.rs2;
  assign ex_rd          = r_idEx.rd;
  assign ex_funct3      = r_idEx.funct3;
  assign ex_alu_op      = r_idEx.aluOp;
  assign ex_alu_src_imm = r_idEx.aluSrcImm;
  assign ex_pc_src      = r_idEx.pcSrc;
  assign ex_mem_read    = r_idEx.memRead;
  assign ex_mem_write   = r_idEx.memWrite;
  assign ex_reg_write   = r_idEx.regWrite;
  assign ex_branch      = r_idEx.branch;
  assign ex_jump        = r_idEx.jump;
  assign ex_jalr        = r_idEx.jalr;
  assign ex_illegal     = r_idEx.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode fields, load-use bubble, stall/flush and async reset.
module tb_id_stage;

  logic        clk, rst, if_valid, id_ready, ex_ready, flush;
  logic [31:0] if_instr, if_pc, rs1_value_, rs2_value_;
  logic [4:0]  addr_rs1, addr_rs2, ex_rs1, ex_rs2, ex_rd;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_value, ex_rs2_value, ex_imm;
  logic [2:0]  ex_funct3;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src_imm, ex_pc_src, ex_mem_read, ex_mem_write, ex_reg_write;
  logic        ex_branch, ex_jump, ex_jalr, ex_illegal;

  int checkCount = 0;
  int errorCount = 0;

  id_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .ex_ready(ex_ready), .flush(flush),
    .addr_rs1(addr_rs1), .addr_rs2(addr_rs2),
    .rs1_value_(rs1_value_), .rs2_value_(rs2_value_),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_value(ex_rs1_value),
    .ex_rs2_value(ex_rs2_value), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_alu_op(ex_alu_op), .ex_alu_src_imm(ex_alu_src_imm), .ex_pc_src(ex_pc_src),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jalr(ex_jalr), .ex_illegal(ex_illegal)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] instr, input logic [31:0] pc);
    if_valid = valid;
    if_instr = instr;
    if_pc    = pc;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // Main directed sequence
  initial begin
    rst = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    rs1_value_ = 32'hAAAA_0001; rs2_value_ = 32'hBBBB_0002;
    applyStimulus(1'b1, 32'h0050_0093, 32'h0000_0000);
    #12;
    checkOutput("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("reset_ex_pc", ex_pc, 32'd0);
    checkOutput("reset_id_ready", {31'd0, id_ready}, 32'd1);
    checkOutput("addr_rs1", {27'd0, addr_rs1}, 32'd0);
    checkOutput("addr_rs2", {27'd0, addr_rs2}, 32'd5);
    rst = 1'b1;

    // addi x1,x0,5 captured on the first edge after reset
    stepClock();
    checkOutput("addi_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("addi_rd", {27'd0, ex_rd}, 32'd1);
    checkOutput("addi_imm", ex_imm, 32'd5);
    checkOutput("addi_aluop", {28'd0, ex_alu_op}, 32'd0);
    checkOutput("addi_srcimm", {31'd0, ex_alu_src_imm}, 32'd1);
    checkOutput("addi_regwr", {31'd0, ex_reg_write}, 32'd1);
    checkOutput("addi_rs1val", ex_rs1_value, 32'hAAAA_0001);

    // lw x2,0(x1) followed by dependent add x3,x2,x1
    rs2_value_ = 32'h1234_5678;
    applyStimulus(1'b1, 32'h0000_A103, 32'h0000_0004);
    stepClock();
    checkOutput("lw_memrd", {31'd0, ex_mem_read}, 32'd1);
    checkOutput("lw_rd", {27'd0, ex_rd}, 32'd2);
    checkOutput("lw_pc", ex_pc, 32'h4);
    applyStimulus(1'b1, 32'h0011_01B3, 32'h0000_0008);
    #1;
    checkOutput("lu_id_ready", {31'd0, id_ready}, 32'd0);
    stepClock();
    checkOutput("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("lu_bubble_memrd", {31'd0, ex_mem_read}, 32'd0);
    checkOutput("lu_bubble_regwr", {31'd0, ex_reg_write}, 32'd0);
    checkOutput("lu_ready_again", {31'd0, id_ready}, 32'd1);
    stepClock();
    checkOutput("add_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("add_rs1", {27'd0, ex_rs1}, 32'd2);
    checkOutput("add_rs2", {27'd0, ex_rs2}, 32'd1);
    checkOutput("add_rd", {27'd0, ex_rd}, 32'd3);
    checkOutput("add_aluop", {28'd0, ex_alu_op}, 32'd0);
    checkOutput("add_srcimm", {31'd0, ex_alu_src_imm}, 32'd0);
    checkOutput("add_rs2val", ex_rs2_value, 32'h1234_5678);

    // beq x0,x0,-8
    applyStimulus(1'b1, 32'hFE00_0CE3, 32'h0000_000C);
    stepClock();
    checkOutput("beq_imm", ex_imm, 32'hFFFF_FFF8);
    checkOutput("beq_branch", {31'd0, ex_branch}, 32'd1);
    checkOutput("beq_aluop", {28'd0, ex_alu_op}, 32'd1);
    checkOutput("beq_regwr", {31'd0, ex_reg_write}, 32'd0);

    // sub x5,x6,x7 and srai x1,x1,3
    applyStimulus(1'b1, 32'h4073_02B3, 32'h0000_0010);
    stepClock();
    checkOutput("sub_aluop", {28'd0, ex_alu_op}, 32'd1);
    applyStimulus(1'b1, 32'h4030_D093, 32'h0000_0014);
    stepClock();
    checkOutput("srai_aluop", {28'd0, ex_alu_op}, 32'd7);

    // sw x2,8(x1)
    applyStimulus(1'b1, 32'h0020_A423, 32'h0000_0018);
    stepClock();
    checkOutput("sw_imm", ex_imm, 32'd8);
    checkOutput("sw_memwr", {31'd0, ex_mem_write}, 32'd1);
    checkOutput("sw_regwr", {31'd0, ex_reg_write}, 32'd0);

    // lui x5,0x12345
    applyStimulus(1'b1, 32'h1234_52B7, 32'h0000_001C);
    stepClock();
    checkOutput("lui_imm", ex_imm, 32'h1234_5000);
    checkOutput("lui_aluop", {28'd0, ex_alu_op}, 32'd10);

    // jal x1,+16: J-immediate 16
    applyStimulus(1'b1, 32'h0100_00EF, 32'h0000_0020);
    stepClock();
    checkOutput("jal_imm", ex_imm, 32'd16);
    checkOutput("jal_pcsrc", {31'd0, ex_pc_src}, 32'd1);

    // Illegal opcode
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h0000_0024);
    stepClock();
    checkOutput("ill_illegal", {31'd0, ex_illegal}, 32'd1);
    checkOutput("ill_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("ill_ctrls", {25'd0, ex_alu_src_imm, ex_pc_src, ex_mem_read, ex_mem_write,
                              ex_reg_write, ex_branch, ex_jump}, 32'd0);

    // addi x0,x0,1 never writes
    applyStimulus(1'b1, 32'h0010_0013, 32'h0000_0028);
    stepClock();
    checkOutput("x0_regwr", {31'd0, ex_reg_write}, 32'd0);
    checkOutput("x0_valid", {31'd0, ex_valid}, 32'd1);

    // Stall for three cycles, then flush while still stalled
    applyStimulus(1'b1, 32'h0050_0093, 32'h0000_0040);
    stepClock();
    ex_ready = 1'b0;
    applyStimulus(1'b1, 32'h1234_52B7, 32'h0000_0044);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("stall_id_ready", {31'd0, id_ready}, 32'd0);
      stepClock();
      checkOutput("stall_imm", ex_imm, 32'd5);
      checkOutput("stall_pc", ex_pc, 32'h40);
      checkOutput("stall_valid", {31'd0, ex_valid}, 32'd1);
    end
    flush = 1'b1;
    stepClock();
    checkOutput("flush_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("flush_regwr", {31'd0, ex_reg_write}, 32'd0);
    flush = 1'b0;
    ex_ready = 1'b1;

    // Empty slot yields a bubble
    applyStimulus(1'b0, 32'h0050_0093, 32'h0000_0048);
    stepClock();
    checkOutput("empty_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("empty_srcimm", {31'd0, ex_alu_src_imm}, 32'd0);

    // Async reset mid-cycle clears outputs before the next edge
    applyStimulus(1'b1, 32'h0050_0093, 32'h0000_004C);
    stepClock();
    checkOutput("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("async_rst_imm", ex_imm, 32'd0);
    checkOutput("async_rst_pc", ex_pc, 32'd0);
    checkOutput("async_rst_regwr", {31'd0, ex_reg_write}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the instruction whose decode is used for bubbles (control fields only).
REQ-002 SHALL have ports (name direction width meaning):
 clk  in  1  sole clock, rising edge;
 rst  in  1  asynchronous, active-low reset;
 if_valid  in  1  IF/ID slot holds an instruction;
 if_instr  in  32  instruction word;
 if_pc  in  32  instruction PC;
 id_ready  out  1  ID accepts the IF/ID slot this cycle;
 ex_ready  in  1  EX accepts the ID/EX slot this cycle;
 flush  in  1  EX-resolved redirect, kill ID/EX contents;
 addr_rs1, addr_rs2  out  5 each  register file read addresses;
 rs1_value_, rs2_value_  in  32 each  register file read data, already write-forwarded;
 ex_valid  out  1;  ex_pc  out  32;  ex_rs1_value, ex_rs2_value, ex_imm  out  32 each;
 ex_rs1, ex_rs2, ex_rd  out  5 each;  ex_funct3  out  3;  ex_alu_op  out  4;
 ex_alu_src_imm, ex_pc_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump, ex_jalr, ex_illegal  out  1 each.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-004 addr_rs1 = if_instr[19:15], addr_rs2 = if_instr[24:20], combinational, always driven.
REQ-005 Decode RV32I opcodes LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011; any other opcode sets ex_illegal=1, all other controls 0.
REQ-006 Immediates sign-extended to 32 bits: I, S, B (bit0=0), U (low 12 = 0), J (bit0=0); OP/illegal imm=0.
REQ-007 ex_alu_op encoding: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10; SUB/SRA only when funct7[5]=1 (SUB for OP only; SRAI for OP-IMM); LUI=PASSB; AUIPC/LOAD/STORE/JAL/JALR=ADD; BRANCH=SUB.
REQ-008 ex_alu_src_imm=1 for all except OP and BRANCH; ex_pc_src=1 for AUIPC, JAL.
REQ-009 ex_reg_write=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP and forced 0 when rd=0.
REQ-010 uses_rs1 = not (LUI, AUIPC, JAL); uses_rs2 = BRANCH, STORE, OP.
REQ-011 load_use = ex_valid & ex_mem_read & (ex_rd!=0) & if_valid & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
REQ-012 id_ready = ex_ready & ~load_use, combinational; flush does not affect id_ready.
REQ-013 ID/EX register update priority per rising edge: (1) flush -> bubble; (2) ~ex_ready -> hold all outputs; (3) load_use -> bubble; (4) else capture decode of current slot, ex_valid<=if_valid.
REQ-014 Bubble: ex_valid=0 and all 1-bit controls 0 (incl. ex_illegal); data fields don't-care but SHALL be 0.
REQ-015 if_valid=0 captured SHALL produce a bubble (controls 0).
REQ-016 Latency: one cycle from accepted IF/ID slot to ID/EX outputs; load-use costs exactly one bubble.
REQ-017 ex_rs1_value/ex_rs2_value SHALL be sampled from rs1_value_/rs2_value_ at the capture edge (same-cycle writeback forwarded by the register file).

Reset
REQ-018 While rst=0 all ID/EX outputs SHALL be 0 asynchronously; id_ready follows REQ-012 with ex_valid=0.
REQ-019 First edge after rst rises SHALL behave per REQ-013 with no extra wait cycle.

Verification
REQ-020 if_instr=0x00500093 (addi x1,x0,5), ex_ready=1 -> next cycle ex_valid=1, ex_rd=1, ex_imm=5, ex_alu_op=0, ex_alu_src_imm=1, ex_reg_write=1.
REQ-021 lw x2,0(x1) (0x0000A103) then add x3,x2,x1 (0x001101B3) -> id_ready=0 one cycle, one bubble, then add captured with ex_rs1=2, ex_rs2=1, ex_alu_op=0.
REQ-022 beq x0,x0,-8 (0xFE000CE3) -> ex_imm=0xFFFFFFF8, ex_branch=1, ex_alu_op=1, ex_reg_write=0.
REQ-023 ex_ready=0 for 3 cycles with valid slot -> ID/EX outputs unchanged, id_ready=0; flush=1 asserted with ex_ready=0 -> ex_valid=0 next edge.
REQ-024 if_instr=0xFFFFFFFF -> ex_illegal=1, ex_valid=1, all other controls 0; addi x0,x0,1 -> ex_reg_write=0.
REQ-025 rst driven low mid-stream between edges -> all outputs 0 immediately, before the next clk edge.
